// File: rtl/list_build.sv
// Builds a singly linked list in a 2^ADDR_W x 32 RAM from a valid/ready value stream.
// Node k holds its value at word 2k and its next pointer at word 2k+1; a zero pointer ends the list.
module list_build #(
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [31:0]       data_in,
   input  logic              data_valid,
   input  logic              data_last,
   output logic              data_ready,
   output logic              DONE,
   output logic [ADDR_W-1:0] node_cnt,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [31:0]       rd_data
);

   localparam int DEPTH     = 1 << ADDR_W;
   localparam int MAX_NODES = 1 << (ADDR_W - 1);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MAX_NODES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_WR_VAL,
      ST_WR_NEXT,
      ST_FIN
   } state_t;

   state_t            r_state;
   logic              r_data_ready;
   logic              r_done;
   logic [ADDR_W-1:0] r_node_cnt;
   logic [31:0]       r_val;
   logic              r_last;
   logic [31:0]       r_mem [DEPTH];

   logic              w_final;
   logic [ADDR_W-1:0] w_val_addr;
   logic [ADDR_W-1:0] w_next_addr;
   logic [31:0]       w_next_ptr;
   logic              w_we;
   logic [ADDR_W-1:0] w_wr_addr;
   logic [31:0]       w_wr_data;

   // A full list forces termination regardless of the captured last flag.
   assign w_final     = r_last || (r_node_cnt == LAST_IDX);
   assign w_val_addr  = {r_node_cnt[ADDR_W-2:0], 1'b0};
   assign w_next_addr = {r_node_cnt[ADDR_W-2:0], 1'b1};
   assign w_next_ptr  = 32'(w_val_addr) + 32'd2;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_we      = 1'b0;
      w_wr_addr = '0;
      w_wr_data = '0;
      if (!rst) begin
         case (r_state)
            ST_WR_VAL: begin
               w_we      = 1'b1;
               w_wr_addr = w_val_addr;
               w_wr_data = r_val;
            end
            ST_WR_NEXT: begin
               w_we      = 1'b1;
               w_wr_addr = w_next_addr;
               w_wr_data = w_final ? 32'd0 : w_next_ptr;
            end
            default: begin
               w_we      = 1'b0;
               w_wr_addr = '0;
               w_wr_data = '0;
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_data_ready <= 1'b0;
         r_done       <= 1'b0;
         r_node_cnt   <= '0;
         r_val        <= '0;
         r_last       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state      <= ST_WAIT;
                  r_data_ready <= 1'b1;
                  r_node_cnt   <= '0;
               end
            end
            ST_WAIT: begin
               if (data_valid) begin
                  r_val        <= data_in;
                  r_last       <= data_last;
                  r_data_ready <= 1'b0;
                  r_state      <= ST_WR_VAL;
               end
            end
            ST_WR_VAL: begin
               r_state <= ST_WR_NEXT;
            end
            ST_WR_NEXT: begin
               r_node_cnt <= r_node_cnt + ADDR_W'(1);
               if (w_final) begin
                  r_state <= ST_FIN;
                  r_done  <= 1'b1;
               end else begin
                  r_state      <= ST_WAIT;
                  r_data_ready <= 1'b1;
               end
            end
            ST_FIN: begin
               if (start) begin
                  r_state      <= ST_WAIT;
                  r_done       <= 1'b0;
                  r_data_ready <= 1'b1;
                  r_node_cnt   <= '0;
               end
            end
            default: begin
               r_state      <= ST_IDLE;
               r_data_ready <= 1'b0;
               r_done       <= 1'b0;
            end
         endcase
      end
   end

   // NOTE: the list RAM has no reset; a previous list stays readable until overwritten.
   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[w_wr_addr] <= w_wr_data;
      end
   end

   assign rd_data    = r_mem[rd_addr];
   assign data_ready = r_data_ready;
   assign DONE       = r_done;
   assign node_cnt   = r_node_cnt;

endmodule

// File: tb/tb_list_build.sv
// Directed and random list builds for list_build, checked against a queue-based list model.
module tb_list_build;

   localparam int ADDR_W    = 5;
   localparam int DEPTH     = 1 << ADDR_W;
   localparam int MAX_NODES = 1 << (ADDR_W - 1);

   logic              clk;
   logic              rst;
   logic              start;
   logic [31:0]       data_in;
   logic              data_valid;
   logic              data_last;
   logic              data_ready;
   logic              DONE;
   logic [ADDR_W-1:0] node_cnt;
   logic [ADDR_W-1:0] rd_addr;
   logic [31:0]       rd_data;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_mem   [DEPTH];
   bit          exp_valid [DEPTH];

   list_build #(.ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_last  (data_last),
      .data_ready (data_ready),
      .DONE       (DONE),
      .node_cnt   (node_cnt),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // List model: walks the values, stops at the first last flag or when the RAM is full.
   function automatic int model_build(input logic [31:0] vals[$], input bit lasts[$]);
      for (int i = 0; i < vals.size(); i++) begin
         bit fin = lasts[i] || (i == MAX_NODES - 1);
         exp_mem[2*i]       = vals[i];
         exp_mem[2*i+1]     = fin ? 32'd0 : 32'(2*i + 2);
         exp_valid[2*i]     = 1'b1;
         exp_valid[2*i+1]   = 1'b1;
         if (fin) return i + 1;
      end
      return vals.size();
   endfunction

   task automatic check_mem(input string tag);
      for (int a = 0; a < DEPTH; a++) begin
         if (exp_valid[a]) begin
            rd_addr = ADDR_W'(a);
            #1;
            check($sformatf("%s mem[%0d]", tag, a), rd_data, exp_mem[a]);
         end
      end
   endtask

   task automatic do_start(input string tag);
      start = 1'b1;
      step();
      start = 1'b0;
      check({tag, " ready_after_start"}, 32'(data_ready), 32'd1);
      check({tag, " done_after_start"}, 32'(DONE), 32'd0);
   endtask

   // Presents one value and returns after the edge that accepts it; waited = idle samples before ready.
   task automatic push(input logic [31:0] v, input bit l, output int waited);
      data_in    = v;
      data_last  = l;
      data_valid = 1'b1;
      waited     = 0;
      while (data_ready !== 1'b1 && waited < 20) begin
         step();
         waited++;
      end
      if (waited >= 20) check("ready_timeout", 32'(data_ready), 32'd1);
      step();
   endtask

   task automatic wait_done(input string tag);
      int cyc = 0;
      while (DONE !== 1'b1 && cyc < 10) begin
         step();
         cyc++;
      end
      check({tag, " done"}, 32'(DONE), 32'd1);
      check({tag, " ready_in_fin"}, 32'(data_ready), 32'd0);
   endtask

   task automatic run_list(input string tag, input logic [31:0] vals[$], input bit lasts[$], input int n);
      int waited;
      for (int i = 0; i < n; i++) begin
         push(vals[i], lasts[i], waited);
         if (i > 0) check($sformatf("%s accept_latency[%0d]", tag, i), 32'(waited), 32'd2);
      end
      data_valid = 1'b0;
      data_last  = 1'b0;
      wait_done(tag);
      check({tag, " node_cnt"}, 32'(node_cnt), 32'(n));
   endtask

   initial begin
      logic [31:0] vals[$];
      bit          lasts[$];
      int          n;
      int          waited;

      rst = 1'b1; start = 1'b0; data_in = '0; data_valid = 1'b0; data_last = 1'b0; rd_addr = '0;
      for (int a = 0; a < DEPTH; a++) exp_valid[a] = 1'b0;
      step();
      step();
      rst = 1'b0;
      check("reset ready", 32'(data_ready), 32'd0);
      check("reset done", 32'(DONE), 32'd0);
      check("reset node_cnt", 32'(node_cnt), 32'd0);
      data_valid = 1'b1;
      step();
      data_valid = 1'b0;
      check("idle ignores valid", 32'(data_ready), 32'd0);

      // Three values with valid held high.
      do_start("s1");
      vals = '{32'd5, 32'd7, 32'd9};
      lasts = '{1'b0, 1'b0, 1'b1};
      n = model_build(vals, lasts);
      run_list("s1", vals, lasts, n);
      check_mem("s1");

      // Restart from FIN with a single terminal value; older words stay intact.
      do_start("s2");
      vals = '{32'hDEADBEEF};
      lasts = '{1'b1};
      n = model_build(vals, lasts);
      run_list("s2", vals, lasts, n);
      check_mem("s2");

      // Full list: termination is forced at node 15.
      do_start("s3");
      vals.delete();
      lasts.delete();
      for (int i = 1; i <= MAX_NODES; i++) begin
         vals.push_back(32'(i));
         lasts.push_back(1'b0);
      end
      n = model_build(vals, lasts);
      run_list("s3", vals, lasts, n);
      check("s3 node_cnt16", 32'(node_cnt), 32'd16);
      check_mem("s3");

      // start in WR_VAL and a value held through WR_NEXT are both ignored.
      do_start("s4");
      push(32'd11, 1'b0, waited);
      data_valid = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      data_in = 32'd99; data_last = 1'b1; data_valid = 1'b1;
      check("s4 ready_in_wr_next", 32'(data_ready), 32'd0);
      step();
      check("s4 ready_back_in_wait", 32'(data_ready), 32'd1);
      check("s4 no_restart node_cnt", 32'(node_cnt), 32'd1);
      step();
      data_valid = 1'b0; data_last = 1'b0;
      wait_done("s4");
      vals = '{32'd11, 32'd99};
      lasts = '{1'b0, 1'b1};
      n = model_build(vals, lasts);
      check("s4 node_cnt", 32'(node_cnt), 32'(n));
      check_mem("s4");

      // Reset after two of four values, with start and valid asserted alongside it.
      do_start("s5");
      vals = '{32'd21, 32'd22};
      lasts = '{1'b0, 1'b0};
      push(vals[0], 1'b0, waited);
      push(vals[1], 1'b0, waited);
      data_valid = 1'b0;
      step();
      step();
      check("s5 two_written node_cnt", 32'(node_cnt), 32'd2);
      n = model_build(vals, lasts);
      rst = 1'b1; start = 1'b1; data_valid = 1'b1; data_in = 32'd23;
      step();
      rst = 1'b0; start = 1'b0; data_valid = 1'b0;
      check("s5 rst ready", 32'(data_ready), 32'd0);
      check("s5 rst done", 32'(DONE), 32'd0);
      check("s5 rst node_cnt", 32'(node_cnt), 32'd0);
      step();
      check("s5 stays_idle", 32'(data_ready), 32'd0);
      do_start("s5b");
      vals = '{32'd3, 32'd4};
      lasts = '{1'b0, 1'b1};
      n = model_build(vals, lasts);
      run_list("s5b", vals, lasts, n);
      check_mem("s5b");

      // Random lists, some ended by last and some by the full condition.
      for (int t = 0; t < 6; t++) begin
         int len = $urandom_range(1, 20);
         int mode = $urandom_range(0, 2);
         vals.delete();
         lasts.delete();
         for (int i = 0; i < len; i++) begin
            vals.push_back($urandom);
            lasts.push_back(1'b0);
         end
         if (mode != 0) lasts[$urandom_range(0, len - 1)] = 1'b1;
         else if (len < MAX_NODES) lasts[len - 1] = 1'b1;
         do_start($sformatf("r%0d", t));
         n = model_build(vals, lasts);
         run_list($sformatf("r%0d", t), vals, lasts, n);
         check_mem($sformatf("r%0d", t));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/list_build.md
LIST_BUILD -- requirements
Module: list_build

Interface
REQ-001 The block SHALL have one parameter: ADDR_W, default 5, meaning the word-address width of the internal list RAM (2^ADDR_W words of 32 bits; maximum list length 2^(ADDR_W-1) nodes).
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 Port start, input, 1 bit: begin a new list build; sampled only in IDLE or FIN.
REQ-005 Port data_in, input, 32 bits: value to store in the next node.
REQ-006 Port data_valid, input, 1 bit: data_in is valid.
REQ-007 Port data_last, input, 1 bit: the current value is the final node; qualified by data_valid.
REQ-008 Port data_ready, output, 1 bit: the block accepts a value this cycle.
REQ-009 Port DONE, output, 1 bit: the list is complete and terminated.
REQ-010 Port node_cnt, output, ADDR_W bits: number of nodes written in the current or last build.
REQ-011 Port rd_addr, input, ADDR_W bits: read address for the list consumer or the bench.
REQ-012 Port rd_data, output, 32 bits: combinational read, mem[rd_addr].

Function
REQ-013 Memory layout SHALL be fixed: node k occupies words 2k (value) and 2k+1 (next pointer); the head node SHALL be at address 0.
REQ-014 The next pointer of a non-final node k SHALL be 2k+2; the next pointer of the final node SHALL be 0, which terminates the list for a NEXT_ZERO-style reader.
REQ-015 The FSM SHALL have the states IDLE, WAIT, WR_VAL, WR_NEXT and FIN.
REQ-016 IDLE: data_ready=0, DONE=0; start=1 -> WAIT, with node_cnt cleared to 0.
REQ-017 WAIT: data_ready=1; data_valid=1 -> capture data_in and data_last into registers, then go to WR_VAL; otherwise stay in WAIT.
REQ-018 WR_VAL: data_ready=0; write mem[2*node_cnt]=captured value; go to WR_NEXT.
REQ-019 WR_NEXT: data_ready=0; write mem[2*node_cnt+1]=next pointer per REQ-014; increment node_cnt; if the node is final -> FIN, else -> WAIT.
REQ-020 A node SHALL be final if the captured data_last=1 or node_cnt = 2^(ADDR_W-1)-1 (list full); in the full case the captured data_last is ignored and termination is forced.
REQ-021 Accept-to-next-ready latency SHALL be exactly 3 cycles; at most one value SHALL be accepted per 3 cycles.
REQ-022 FIN: DONE=1 (held as a level), data_ready=0, node_cnt frozen; start=1 -> WAIT with node_cnt cleared and DONE=0 on the next cycle.
REQ-023 start SHALL be ignored in WAIT, WR_VAL and WR_NEXT.
REQ-024 data_valid SHALL be ignored in every state other than WAIT; values presented there are not stored.
REQ-025 At most one RAM write SHALL occur per cycle; RAM contents outside written nodes SHALL be left unchanged.
REQ-026 rd_data SHALL reflect a write on the cycle after the write edge.

Reset
REQ-027 With rst=1 at a clock edge: state=IDLE, data_ready=0, DONE=0, node_cnt=0, capture registers=0.
REQ-028 RAM contents SHALL NOT be cleared by reset.
REQ-029 Reset mid-build SHALL abort the build; a subsequent start SHALL rebuild from node 0.
REQ-030 rst SHALL take priority over start and data_valid in the same cycle.

Verification
REQ-031 Scenario: rst; start; values 5, 7 and 9 (last on 9), valid held high -> mem[0..5] = 5, 2, 7, 4, 9, 0; DONE=1; node_cnt=3; data_ready high for 1 cycle of every 3.
REQ-032 Scenario: single value 0xDEADBEEF with last=1 -> mem[0]=0xDEADBEEF, mem[1]=0, DONE=1, node_cnt=1.
REQ-033 Scenario: 16 values 1..16 with last never asserted (ADDR_W=5) -> mem[31]=0, mem[29]=30, DONE=1, node_cnt=16 (wraps to 0 in 5 bits is not permitted; the bench checks node_cnt=16).
REQ-034 Scenario: start pulsed in WR_VAL, and data_valid held in WR_NEXT with value 99 -> no restart; 99 is neither stored nor accepted until WAIT.
REQ-035 Scenario: rst after 2 of 4 values -> IDLE, DONE=0, node_cnt=0; a new start with values 3 and 4 (last) -> mem[0..3] = 3, 2, 4, 0.
REQ-036 Scenario: start asserted in FIN -> DONE drops on the next cycle and data_ready=1; a second list overwrites from address 0.
